// File: rtl/bsnce_pkg.sv
// bsnce_pkg: shared types and constants for the bit-serial MAC front end.
// Holds the bank state encoding, default vector geometry and the beat-count helper.
package bsnce_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_state_e;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_N_IN   = 128;

  // Number of input beats needed to assemble one vector.
  function automatic int beats(input int n_in, input int lanes);
    return n_in / lanes;
  endfunction

endpackage

// File: rtl/ibuf_bank.sv
// ibuf_bank: one storage bank of the ping-pong input buffer.
// Each accepted beat writes LANES words at word offset beat_idx_i*LANES; the whole
// bank is presented packed on rd_data_o (word i at [(i+1)*DATA_W-1 -: DATA_W]).
module ibuf_bank
  import bsnce_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int N_IN   = DEF_N_IN,
  parameter  int LANES  = 1,
  localparam int BEATS  = beats(N_IN, LANES),
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en_i,
  input  logic [CNT_W-1:0]          beat_idx_i,
  input  logic [LANES*DATA_W-1:0]   wr_data_i,
  output logic [N_IN*DATA_W-1:0]    rd_data_o
);

  logic [N_IN*DATA_W-1:0] mem_q;

  // Beat-indexed lane write; each word slot compares its own beat index so all
  // part-selects are static after unrolling. Bank clears to zero on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (wr_en_i) begin
      for (int w = 0; w < N_IN; w++) begin
        if (CNT_W'(w / LANES) == beat_idx_i) begin
          mem_q[w*DATA_W +: DATA_W] <= wr_data_i[(w % LANES)*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign rd_data_o = mem_q;

endmodule

// File: rtl/input_buffer_pp.sv
// input_buffer_pp: double-buffered (ping-pong) vector input buffer.
// Assembles N_IN-word vectors from a LANES-wide valid/ready stream into the write
// bank while the consumer reads the other bank. Malformed vectors (early or
// missing s_last) are discarded and flagged with one-cycle pulses.
// Optional feature macro: INPUT_BUFFER_ERR_CNT_EN enables the saturating
// discarded-vector counter on err_count (tied to zero otherwise).
module input_buffer_pp
  import bsnce_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_IN   = DEF_N_IN,
  parameter int LANES  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES*DATA_W-1:0] s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic [N_IN*DATA_W-1:0]  invec_bus,
  output logic                    vec_valid,
  input  logic                    vec_release,
  output logic                    err_short,
  output logic                    err_long,
  output logic [15:0]             err_count
);

  localparam int BEATS = beats(N_IN, LANES);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if (N_IN % LANES != 0) begin : g_lanes_chk
    $fatal(1, "input_buffer_pp: N_IN must be a multiple of LANES");
  end

  bank_state_e       st_q [2];
  bank_state_e       st_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              s_ready_q, s_ready_d;
  logic              err_short_q, err_short_d;
  logic              err_long_q, err_long_d;

  logic accept, final_beat, commit, release_ok;

  assign accept     = s_valid && s_ready_q;
  assign final_beat = (cnt_q == LAST_BEAT);
  assign commit     = accept && s_last && final_beat;
  assign release_ok = vec_release && (st_q[rd_ptr_q] == FULL);

  // Next-state: beat counter, error pulses, bank commit/release and pointer toggles.
  // Commit and release target different banks whenever both can occur.
  always_comb begin
    st_d        = st_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    if (accept) begin
      if (s_last || final_beat) cnt_d = '0;
      else                      cnt_d = cnt_q + 1'b1;
      err_short_d = s_last && !final_beat;
      err_long_d  = !s_last && final_beat;
    end
    if (commit) begin
      st_d[wr_ptr_q] = FULL;
      wr_ptr_d       = ~wr_ptr_q;
    end
    if (release_ok) begin
      st_d[rd_ptr_q] = EMPTY;
      rd_ptr_d       = ~rd_ptr_q;
    end
    // Ready is registered from next occupancy so it never depends on s_valid.
    s_ready_d = !((st_d[0] == FULL) && (st_d[1] == FULL));
  end

  // Control state registers; reset discards any fill or pending vector silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q[0]     <= EMPTY;
      st_q[1]     <= EMPTY;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= '0;
      s_ready_q   <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      st_q        <= st_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      s_ready_q   <= s_ready_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
    end
  end

  logic [N_IN*DATA_W-1:0] bank_data [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ibuf_bank #(
      .DATA_W (DATA_W),
      .N_IN   (N_IN),
      .LANES  (LANES)
    ) u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en_i    (accept && (wr_ptr_q == 1'(b))),
      .beat_idx_i (cnt_q),
      .wr_data_i  (s_data),
      .rd_data_o  (bank_data[b])
    );
  end

  assign invec_bus = bank_data[rd_ptr_q];
  assign vec_valid = (st_q[rd_ptr_q] == FULL);
  assign s_ready   = s_ready_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;

`ifdef INPUT_BUFFER_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Count discarded vectors, holding at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if ((err_short_d || err_long_d) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_count = err_cnt_q;

`ifndef SYNTHESIS
  // Report each discarded vector in simulation logs.
  always_ff @(posedge clk) begin
    if (rst_n && err_short_d) $error("input_buffer_pp: s_last before final beat, vector discarded");
    if (rst_n && err_long_d)  $error("input_buffer_pp: final beat without s_last, vector discarded");
  end
`endif
`else
  assign err_count = 16'd0;
`endif

endmodule

// File: tb/tb_input_buffer_pp.sv
// Testbench for input_buffer_pp: two instances (N_IN=4/LANES=1 and N_IN=8/LANES=4)
// with a vector scoreboard per instance.
module tb_input_buffer_pp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [15:0]  a_data;
  logic         a_valid, a_last, a_ready, a_vv, a_rel, a_es, a_el;
  logic [63:0]  a_bus;
  logic [15:0]  a_cnt;

  logic [63:0]  b_data;
  logic         b_valid, b_last, b_ready, b_vv, b_rel, b_es, b_el;
  logic [127:0] b_bus;
  logic [15:0]  b_cnt;

  int checks = 0;
  int errors = 0;

  logic [63:0]  qa [$];
  logic [127:0] qb [$];

`ifdef INPUT_BUFFER_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  input_buffer_pp #(.DATA_W(16), .N_IN(4), .LANES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .s_data(a_data), .s_valid(a_valid), .s_last(a_last),
    .s_ready(a_ready), .invec_bus(a_bus), .vec_valid(a_vv), .vec_release(a_rel),
    .err_short(a_es), .err_long(a_el), .err_count(a_cnt)
  );

  input_buffer_pp #(.DATA_W(16), .N_IN(8), .LANES(4)) u_b (
    .clk(clk), .rst_n(rst_n), .s_data(b_data), .s_valid(b_valid), .s_last(b_last),
    .s_ready(b_ready), .invec_bus(b_bus), .vec_valid(b_vv), .vec_release(b_rel),
    .err_short(b_es), .err_long(b_el), .err_count(b_cnt)
  );

  task automatic beat_a(input logic [15:0] w, input logic last);
    int n = 0;
    while (a_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (a_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL a_ready_wait got %b want 1", a_ready);
    end
    a_data = w; a_valid = 1'b1; a_last = last;
    @(posedge clk); #1;
    a_valid = 1'b0; a_last = 1'b0;
  endtask

  task automatic beat_b(input logic [63:0] d, input logic last);
    int n = 0;
    while (b_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (b_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL b_ready_wait got %b want 1", b_ready);
    end
    b_data = d; b_valid = 1'b1; b_last = last;
    @(posedge clk); #1;
    b_valid = 1'b0; b_last = 1'b0;
  endtask

  task automatic send_vec_a(input logic [15:0] base);
    qa.push_back({base + 16'd3, base + 16'd2, base + 16'd1, base});
    for (int i = 0; i < 4; i++) beat_a(base + 16'(i), (i == 3));
  endtask

  task automatic send_vec_b(input logic [127:0] v);
    qb.push_back(v);
    beat_b(v[63:0], 1'b0);
    beat_b(v[127:64], 1'b1);
  endtask

  task automatic pop_a(input string nm);
    logic [63:0] exp;
    int n = 0;
    while (a_vv !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (a_vv !== 1'b1) begin
      errors++;
      $display("FAIL %s_a_vv got %b want 1", nm, a_vv);
    end
    checks++;
    if (qa.size() == 0) begin
      errors++;
      $display("FAIL %s_a_queue got empty want entry", nm);
    end else begin
      exp = qa.pop_front();
      if (a_bus !== exp) begin
        errors++;
        $display("FAIL %s_a_bus got %h want %h", nm, a_bus, exp);
      end
    end
  endtask

  task automatic pop_b(input string nm);
    logic [127:0] exp;
    int n = 0;
    while (b_vv !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (b_vv !== 1'b1) begin
      errors++;
      $display("FAIL %s_b_vv got %b want 1", nm, b_vv);
    end
    checks++;
    if (qb.size() == 0) begin
      errors++;
      $display("FAIL %s_b_queue got empty want entry", nm);
    end else begin
      exp = qb.pop_front();
      if (b_bus !== exp) begin
        errors++;
        $display("FAIL %s_b_bus got %h want %h", nm, b_bus, exp);
      end
    end
  endtask

  task automatic release_a();
    @(posedge clk); #1;
    a_rel = 1'b1;
    @(posedge clk); #1;
    a_rel = 1'b0;
  endtask

  task automatic release_b();
    @(posedge clk); #1;
    b_rel = 1'b1;
    @(posedge clk); #1;
    b_rel = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_data = '0; a_valid = 1'b0; a_last = 1'b0; a_rel = 1'b0;
    b_data = '0; b_valid = 1'b0; b_last = 1'b0; b_rel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_a_ready got %b want 0", a_ready); end
    checks++; if (a_vv !== 1'b0)    begin errors++; $display("FAIL rst_a_vv got %b want 0", a_vv); end
    checks++; if (a_es !== 1'b0 || a_el !== 1'b0) begin errors++; $display("FAIL rst_a_err got %b%b want 00", a_es, a_el); end
    checks++; if (a_cnt !== 16'd0)  begin errors++; $display("FAIL rst_a_cnt got %h want 0", a_cnt); end
    checks++; if (a_bus !== 64'd0)  begin errors++; $display("FAIL rst_a_bus got %h want 0", a_bus); end
    checks++; if (b_ready !== 1'b0 || b_vv !== 1'b0) begin errors++; $display("FAIL rst_b_ctl got %b%b want 00", b_ready, b_vv); end
    checks++; if (b_bus !== 128'd0) begin errors++; $display("FAIL rst_b_bus got %h want 0", b_bus); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_a_ready_after got %b want 1", a_ready); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL rst_b_ready_after got %b want 1", b_ready); end
  endtask

  task automatic test_single();
    send_vec_a(16'd1);
    checks++; if (a_vv !== 1'b1) begin errors++; $display("FAIL single_latency got %b want 1", a_vv); end
    pop_a("single");
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", a_ready); end
    release_a();
    checks++; if (a_vv !== 1'b0) begin errors++; $display("FAIL single_release got %b want 0", a_vv); end
  endtask

  task automatic test_short();
    beat_a(16'h0010, 1'b1);
    checks++; if (a_es !== 1'b1) begin errors++; $display("FAIL short_pulse got %b want 1", a_es); end
    checks++; if (a_el !== 1'b0 || a_vv !== 1'b0) begin errors++; $display("FAIL short_side got el=%b vv=%b want 0 0", a_el, a_vv); end
    @(posedge clk); #1;
    checks++; if (a_es !== 1'b0) begin errors++; $display("FAIL short_pulse_end got %b want 0", a_es); end
    checks++; if (a_cnt !== (CNT_EN ? 16'd1 : 16'd0)) begin errors++; $display("FAIL short_count got %0d want %0d", a_cnt, CNT_EN ? 1 : 0); end
    send_vec_a(16'd5);
    pop_a("after_short");
    release_a();
  endtask

  task automatic test_long_and_overlap();
    logic [15:0] y;
    for (int i = 0; i < 4; i++) beat_a(16'h0100 + 16'(i), 1'b0);
    checks++; if (a_el !== 1'b1) begin errors++; $display("FAIL long_pulse got %b want 1", a_el); end
    checks++; if (a_es !== 1'b0 || a_vv !== 1'b0) begin errors++; $display("FAIL long_side got es=%b vv=%b want 0 0", a_es, a_vv); end
    @(posedge clk); #1;
    checks++; if (a_el !== 1'b0) begin errors++; $display("FAIL long_pulse_end got %b want 0", a_el); end
    checks++; if (a_cnt !== (CNT_EN ? 16'd2 : 16'd0)) begin errors++; $display("FAIL long_count got %0d want %0d", a_cnt, CNT_EN ? 2 : 0); end
    send_vec_a(16'h0200);
    pop_a("x_vec");
    // Second vector of signed words; final beat coincides with release of the first.
    y = 16'hFFF0;
    qa.push_back({y + 16'd3, y + 16'd2, y + 16'd1, y});
    for (int i = 0; i < 3; i++) beat_a(y + 16'(i), 1'b0);
    a_data = y + 16'd3; a_valid = 1'b1; a_last = 1'b1; a_rel = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0; a_last = 1'b0; a_rel = 1'b0;
    checks++; if (a_vv !== 1'b1) begin errors++; $display("FAIL overlap_vv got %b want 1", a_vv); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL overlap_ready got %b want 1", a_ready); end
    pop_a("overlap");
    release_a();
    checks++; if (a_vv !== 1'b0) begin errors++; $display("FAIL overlap_drain got %b want 0", a_vv); end
  endtask

  task automatic test_two_bank();
    logic [127:0] v1, v2;
    for (int i = 0; i < 8; i++) begin
      v1[i*16 +: 16] = 16'(i + 1);
      v2[i*16 +: 16] = 16'(i - 8);
    end
    send_vec_b(v1);
    checks++; if (b_vv !== 1'b1) begin errors++; $display("FAIL b_first_latency got %b want 1", b_vv); end
    send_vec_b(v2);
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL b_full_ready got %b want 0", b_ready); end
    // A beat offered while both banks are full must be ignored.
    b_data = 64'hDEAD_BEEF_DEAD_BEEF; b_valid = 1'b1; b_last = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0; b_last = 1'b0;
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL b_full_hold got %b want 0", b_ready); end
    pop_b("b_first");
    release_b();
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL b_release_ready got %b want 1", b_ready); end
    pop_b("b_second");
    release_b();
    checks++; if (b_vv !== 1'b0) begin errors++; $display("FAIL b_drain got %b want 0", b_vv); end
  endtask

  task automatic test_reset_midfill();
    beat_a(16'h0030, 1'b0);
    beat_a(16'h0031, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (a_ready !== 1'b0 || a_vv !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl got rdy=%b vv=%b want 0 0", a_ready, a_vv); end
    checks++; if (a_es !== 1'b0 || a_el !== 1'b0) begin errors++; $display("FAIL mid_rst_err got %b%b want 00", a_es, a_el); end
    checks++; if (a_bus !== 64'd0) begin errors++; $display("FAIL mid_rst_bus got %h want 0", a_bus); end
    checks++; if (a_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_cnt got %h want 0", a_cnt); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_vec_a(16'h0040);
    checks++; if (a_es !== 1'b0 && a_el !== 1'b0) begin errors++; $display("FAIL mid_rst_flag got %b%b want 00", a_es, a_el); end
    pop_a("after_mid_rst");
    release_a();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_short();
    test_long_and_overlap();
    test_two_bank();
    test_reset_midfill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
